div: RTL

DIV -- requirements
Module: div

---
 rtl/div.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/div.sv
// div: signed 16-by-8 restoring divider, one quotient bit per clock.
//
// Ports
//   clk    in   rising-edge clock
//   reset  in   asynchronous active-low reset
//   start  in   begin a division (sampled only in IDLE)
//   N      in   16-bit signed dividend
//   D      in   8-bit signed divisor
//   Q      out  8-bit signed quotient (registered, saturates on overflow)
//   R      out  8-bit signed remainder (registered, sign follows N)
//   valid  out  one-cycle pulse marking new Q/R/ovf/dbz
//   busy   out  high while an operation is in flight
//   ovf    out  true quotient outside [-128, 127]
//   dbz    out  divisor was zero
//
// state | meaning
// IDLE  | waiting for start; operands captured on start
// CALC  | 16 restoring steps on magnitudes, MSB first
// FIX   | sign correction, saturation, output registration
module div (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] N,
  input  logic [7:0]  D,
  output logic [7:0]  Q,
  output logic [7:0]  R,
  output logic        valid,
  output logic        busy,
  output logic        ovf,
  output logic        dbz
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] n_q, n_d;
  logic [7:0]  dmag_q, dmag_d;
  logic        sn_q, sn_d;
  logic        sq_q, sq_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [7:0]  rem_q, rem_d;
  logic [15:0] quo_q, quo_d;
  logic        dz_q, dz_d;
  logic [7:0]  q_q, q_d;
  logic [7:0]  r_q, r_d;
  logic        valid_q, valid_d;
  logic        ovf_q, ovf_d;
  logic        dbz_q, dbz_d;

  logic [15:0] n_abs;
  logic [7:0]  d_abs;
  logic [8:0]  rem_sh;
  logic        ge;
  logic [7:0]  sub8;
  logic        ovf_calc;

  assign n_abs  = N[15] ? (16'd0 - N) : N;
  assign d_abs  = D[7]  ? (8'd0 - D)  : D;

  // Partial remainder is always < |D| <= 128 before the shift, so 8 bits
  // hold it; the shifted value needs 9. When ge is set the difference is
  // below 256, so an 8-bit subtraction is exact.
  assign rem_sh = {rem_q, n_q[15]};
  assign ge     = (rem_sh >= {1'b0, dmag_q});
  assign sub8   = rem_sh[7:0] - dmag_q;

  // Negative quotients may reach magnitude 128; positive ones only 127.
  assign ovf_calc = sq_q ? (quo_q > 16'd128) : (quo_q > 16'd127);

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    dmag_d  = dmag_q;
    sn_d    = sn_q;
    sq_d    = sq_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dz_d    = dz_q;
    q_d     = q_q;
    r_d     = r_q;
    ovf_d   = ovf_q;
    dbz_d   = dbz_q;
    valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          cnt_d = 4'd0;
          rem_d = 8'd0;
          quo_d = 16'd0;
          if (D != 8'd0) begin
            n_d     = n_abs;
            dmag_d  = d_abs;
            sn_d    = N[15];
            sq_d    = N[15] ^ D[7];
            dz_d    = 1'b0;
            state_d = CALC;
          end else begin
            // Raw dividend kept so its low byte can be returned as R.
            n_d     = N;
            dz_d    = 1'b1;
            state_d = FIX;
          end
        end
      end

      CALC: begin
        rem_d = ge ? sub8 : rem_sh[7:0];
        quo_d = {quo_q[14:0], ge};
        n_d   = {n_q[14:0], 1'b0};
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd15) state_d = FIX;
      end

      FIX: begin
        if (dz_q) begin
          q_d   = 8'hFF;
          r_d   = n_q[7:0];
          ovf_d = 1'b0;
          dbz_d = 1'b1;
        end else begin
          if (ovf_calc) q_d = sq_q ? 8'h80 : 8'h7F;
          else          q_d = sq_q ? (8'd0 - quo_q[7:0]) : quo_q[7:0];
          r_d   = sn_q ? (8'd0 - rem_q) : rem_q;
          ovf_d = ovf_calc;
          dbz_d = 1'b0;
        end
        valid_d = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      n_q     <= 16'd0;
      dmag_q  <= 8'd0;
      sn_q    <= 1'b0;
      sq_q    <= 1'b0;
      cnt_q   <= 4'd0;
      rem_q   <= 8'd0;
      quo_q   <= 16'd0;
      dz_q    <= 1'b0;
      q_q     <= 8'd0;
      r_q     <= 8'd0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      dmag_q  <= dmag_d;
      sn_q    <= sn_d;
      sq_q    <= sq_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dz_q    <= dz_d;
      q_q     <= q_d;
      r_q     <= r_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
      dbz_q   <= dbz_d;
    end
  end

  assign Q     = q_q;
  assign R     = r_q;
  assign valid = valid_q;
  assign ovf   = ovf_q;
  assign dbz   = dbz_q;
  assign busy  = (state_q != IDLE);

endmodule
